btn_event: RTL and testbench

// - Consumes the debounced push-button level and turns it into clean single-cycle events.
// - Events: press, release, long-press and auto-repeat, plus a held level and a press counter.
// - Sits directly downstream of the debounce stage, which is sampled on a divided strobe.
// - Resynchronises the level into clk, then feeds the controller FSMs in the same clock domain.

---
 rtl/btn_event.sv | 118 +++++++++++
 tb/tb_btn_event.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// rtl/btn_event.sv - push-button event generator: press/release/long-press/repeat pulses, held level, press counter
module btn_event #(
    parameter int LONG_CYCLES   = 12_500_000,
    parameter int REPEAT_CYCLES = 2_500_000,
    parameter int CNT_W         = 24
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_in,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long_press,
    output logic       o_repeat,
    output logic       o_held,
    output logic [7:0] o_press_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_long_press;
    logic             r_repeat;
    logic             r_held;
    logic [7:0]       r_press_count;

    // The debounced level comes from a strobe-sampled stage, so treat it as asynchronous.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_long_press  <= 1'b0;
            r_repeat      <= 1'b0;
            r_held        <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long_press <= 1'b0;
            r_repeat     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_s2) begin
                        r_state       <= ST_PRESSED;
                        r_press       <= 1'b1;
                        r_held        <= 1'b1;
                        r_press_count <= r_press_count + 8'd1;
                    end
                end
                ST_PRESSED: begin
                    // A release seen on the threshold cycle takes priority over long_press.
                    if (!r_s2) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_cnt     <= '0;
                    end else if (r_cnt == LONG_LAST) begin
                        r_state      <= ST_HELD;
                        r_long_press <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!r_s2) begin
                        r_state   <= ST_IDLE;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                        r_cnt     <= '0;
                    end else if (r_cnt == REPEAT_LAST) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign o_press       = r_press;
    assign o_release     = r_release;
    assign o_long_press  = r_long_press;
    assign o_repeat      = r_repeat;
    assign o_held        = r_held;
    assign o_press_count = r_press_count;

endmodule

// File: tb/tb_btn_event.sv
// tb/tb_btn_event.sv - directed vector bench for btn_event (LONG=8, REPEAT=4, CNT_W=8)
module tb_btn_event;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_in;
    logic       o_press;
    logic       o_release;
    logic       o_long_press;
    logic       o_repeat;
    logic       o_held;
    logic [7:0] o_press_count;
    logic [12:0] w_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_excl = 0;
    int n_pair = 0;
    int n_held = 0;
    bit open_press = 0;
    int q_press[$];
    int q_rel[$];
    int q_long[$];
    int q_rep[$];

    typedef struct {
        logic        in;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[10];

    btn_event #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_in         (i_in),
        .o_press      (o_press),
        .o_release    (o_release),
        .o_long_press (o_long_press),
        .o_repeat     (o_repeat),
        .o_held       (o_held),
        .o_press_count(o_press_count)
    );

    always #5 clk = ~clk;

    assign w_out = {o_press, o_release, o_long_press, o_repeat, o_held, o_press_count};

    function automatic vec_t mk(input logic in, input logic p, input logic r, input logic l,
                                input logic rp, input logic h, input logic [7:0] c);
        vec_t v;
        v.in  = in;
        v.exp = {p, r, l, rp, h, c};
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_q(input string nm, input int act[$], input int n,
                         input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        chk({nm, "_count"}, act.size(), n);
        for (int i = 0; i < n && i < act.size(); i++)
            chk({nm, "_cycle"}, act[i], ex[i]);
    endtask

    task automatic clear_log();
        cyc = 0;
        n_held = 0;
        q_press.delete();
        q_rel.delete();
        q_long.delete();
        q_rep.delete();
    endtask

    task automatic step(input logic v);
        i_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (o_press)      q_press.push_back(cyc);
        if (o_release)    q_rel.push_back(cyc);
        if (o_long_press) q_long.push_back(cyc);
        if (o_repeat)     q_rep.push_back(cyc);
        if (o_held)       n_held++;
        if (int'(o_press) + int'(o_release) + int'(o_long_press) + int'(o_repeat) > 1) n_excl++;
        if (o_press) begin
            if (open_press) n_pair++;
            open_press = 1;
        end
        if (o_release) begin
            if (!open_press) n_pair++;
            open_press = 0;
        end
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        // Reset with the button already down, then a 5-edge press.
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 8'd0);
        tbl[1] = mk(1, 0, 0, 0, 0, 0, 8'd0);
        tbl[2] = mk(1, 1, 0, 0, 0, 1, 8'd1);
        tbl[3] = mk(1, 0, 0, 0, 0, 1, 8'd1);
        tbl[4] = mk(1, 0, 0, 0, 0, 1, 8'd1);
        tbl[5] = mk(0, 0, 0, 0, 0, 1, 8'd1);
        tbl[6] = mk(0, 0, 0, 0, 0, 1, 8'd1);
        tbl[7] = mk(0, 0, 1, 0, 0, 0, 8'd1);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 8'd1);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 8'd1);

        rst  = 1'b1;
        i_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(w_out), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d", i + 1), int'(w_out), int'(tbl[i].exp));
        end
        chk("a_no_long", q_long.size(), 0);
        chk("a_held_cycles", n_held, 5);

        // Long hold: in high 27 edges, long at P+8, repeats every 4, release at P+27.
        clear_log();
        run(1, 27);
        run(0, 6);
        chk_q("b_press", q_press, 1, 3, 0, 0, 0);
        chk_q("b_long", q_long, 1, 11, 0, 0, 0);
        chk_q("b_repeat", q_rep, 4, 15, 19, 23, 27);
        chk_q("b_release", q_rel, 1, 30, 0, 0, 0);
        chk("b_held_cycles", n_held, 27);
        chk("b_count", int'(o_press_count), 2);

        // Release seen on the long-press threshold cycle.
        clear_log();
        run(1, 8);
        run(0, 6);
        chk_q("c_press", q_press, 1, 3, 0, 0, 0);
        chk_q("c_release", q_rel, 1, 11, 0, 0, 0);
        chk("c_no_long", q_long.size(), 0);
        chk("c_no_repeat", q_rep.size(), 0);
        chk("c_count", int'(o_press_count), 3);

        // Release seen on the first repeat threshold cycle.
        clear_log();
        run(1, 12);
        run(0, 6);
        chk_q("c2_long", q_long, 1, 11, 0, 0, 0);
        chk_q("c2_release", q_rel, 1, 15, 0, 0, 0);
        chk("c2_no_repeat", q_rep.size(), 0);
        chk("c2_count", int'(o_press_count), 4);

        // 257 short presses from a fresh reset: counter wraps through 0 and ends at 1.
        rst = 1'b1;
        i_in = 1'b0;
        #1;
        chk("d_reset_count", int'(o_press_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        open_press = 0;
        clear_log();
        for (int i = 0; i < 257; i++) begin
            run(1, 3);
            run(0, 6);
            if (i == 255) chk("d_wrap_to_0", int'(o_press_count), 0);
        end
        chk("d_presses", q_press.size(), 257);
        chk("d_releases", q_rel.size(), 257);
        chk("d_count", int'(o_press_count), 1);
        chk("d_first_press", q_press[0], 3);

        // Reset during a hold at P+10, button still down.
        clear_log();
        run(1, 13);
        chk_q("e_long_before", q_long, 1, 11, 0, 0, 0);
        chk("e_held_before", int'(o_held), 1);
        rst = 1'b1;
        #1;
        chk("e_async_outputs", int'(w_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        open_press = 0;
        clear_log();
        run(1, 11);
        chk_q("e_press_after", q_press, 1, 3, 0, 0, 0);
        chk_q("e_long_after", q_long, 1, 11, 0, 0, 0);
        chk("e_no_release", q_rel.size(), 0);
        chk("e_count", int'(o_press_count), 1);
        run(0, 6);

        chk("mutual_exclusion", n_excl, 0);
        chk("press_release_pairing", n_pair, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
